pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/Pipe_Buf_Reg_PKG.sv | 19 +
 rtl/mc_timer.sv | 66 ++++++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared types for the pipeline hazard controller: forwarding selects and multi-cycle FSM states.
package Pipe_Buf_Reg_PKG;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        HZ_IDLE = 2'b00,
        HZ_BUSY = 2'b01,
        HZ_DONE = 2'b10
    } hz_state_e;

    // Wide enough for the largest load value (MC_LAT-2 with MC_LAT up to 15).
    localparam int unsigned MC_CNT_W = 4;

endpackage

// File: rtl/mc_timer.sv
// Multi-cycle execute timer: IDLE -> BUSY (counting) -> DONE -> IDLE.
module mc_timer
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int unsigned MC_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mc_start,
    output logic mc_hold_c,
    output logic mc_busy,
    output logic mc_done
);

    localparam logic [MC_CNT_W-1:0] LOAD_VAL = MC_CNT_W'(MC_LAT - 2);

    hz_state_e             state_q, state_d;
    logic [MC_CNT_W-1:0]   cnt_q, cnt_d;

    // State and counter registers; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HZ_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and decoded outputs; the counter holds the BUSY cycles still to run.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mc_hold_c = 1'b0;
        mc_busy   = 1'b0;
        mc_done   = 1'b0;
        case (state_q)
            HZ_IDLE: begin
                if (mc_start) begin
                    state_d   = HZ_BUSY;
                    cnt_d     = LOAD_VAL;
                    mc_hold_c = 1'b1;
                end
            end
            HZ_BUSY: begin
                mc_busy   = 1'b1;
                mc_hold_c = 1'b1;
                cnt_d     = (cnt_q == '0) ? '0 : cnt_q - MC_CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = HZ_DONE;
                end
            end
            HZ_DONE: begin
                // The held op leaves EX this cycle; a new start is not accepted here.
                mc_done = 1'b1;
                state_d = HZ_IDLE;
            end
            default: begin
                state_d = HZ_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch flush, multi-cycle hold, stall statistics.
module pipe_hazard_ctrl
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int unsigned RF_ADDR_W = 5,
    parameter int unsigned MC_LAT    = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [RF_ADDR_W-1:0] id_rs1,
    input  logic [RF_ADDR_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [RF_ADDR_W-1:0] ex_rs1,
    input  logic [RF_ADDR_W-1:0] ex_rs2,
    input  logic [RF_ADDR_W-1:0] ex_rd,
    input  logic                 ex_regwrite,
    input  logic                 ex_memread,
    input  logic                 ex_mc_start,
    input  logic [RF_ADDR_W-1:0] mem_rd,
    input  logic                 mem_regwrite,
    input  logic [RF_ADDR_W-1:0] wb_rd,
    input  logic                 wb_regwrite,
    input  logic                 br_taken,
    input  logic                 stat_clr,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic                 hold_front,
    output logic                 flush_ifid,
    output logic                 bubble_idex,
    output logic                 hold_ex,
    output logic                 bubble_exmem,
    output logic                 mc_busy,
    output logic                 mc_done,
    output logic [CNT_W-1:0]     stall_cnt
);

    fwd_sel_e           fwd_a_sel, fwd_b_sel;
    logic               mc_hold_c;
    logic               load_use_c;
    logic               br_eff_c;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    // Load-use detection keys off ex_memread alone; the EX write enable is not needed.
    logic unused_ex_regwrite;
    assign unused_ex_regwrite = ex_regwrite;

    mc_timer #(
        .MC_LAT (MC_LAT)
    ) u_mc_timer (
        .clk       (clk),
        .reset     (reset),
        .mc_start  (ex_mc_start),
        .mc_hold_c (mc_hold_c),
        .mc_busy   (mc_busy),
        .mc_done   (mc_done)
    );

    // Forwarding select: the younger MEM result wins over WB; x0 never forwards.
    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1)) begin
            fwd_a_sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
            fwd_a_sel = FWD_WB;
        end
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2)) begin
            fwd_b_sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
            fwd_b_sel = FWD_WB;
        end
    end

    assign fwd_a = fwd_a_sel;
    assign fwd_b = fwd_b_sel;

    // Stall/flush decisions; a branch flush overrides any front-end hold, and is ignored while BUSY.
    always_comb begin
        load_use_c   = 1'b0;
        br_eff_c     = 1'b0;
        hold_front   = 1'b0;
        flush_ifid   = 1'b0;
        bubble_idex  = 1'b0;
        hold_ex      = mc_hold_c;
        bubble_exmem = mc_hold_c;
        if (ex_memread && (ex_rd != '0) &&
            ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)))) begin
            load_use_c = !mc_done;
        end
        br_eff_c    = br_taken && !mc_busy;
        flush_ifid  = br_eff_c;
        bubble_idex = br_eff_c || load_use_c;
        hold_front  = !br_eff_c && !mc_done && (mc_hold_c || load_use_c);
    end

    // Stall statistics: clear beats increment, increment saturates.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clr) begin
            stall_cnt_d = '0;
        end else if (hold_front && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
